// File: rtl/mul_pipe_arb_if.sv
// Requester-side handshake bundle for the shared multiplier arbiter.
// The master drives requests and response-accept; the slave is the arbiter.
interface mul_pipe_arb_if #(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
);
    localparam int W = 1 + EXPO_W + MANT_W;

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0][W-1:0]   req_a;
    logic [1:0][W-1:0]   req_b;
    logic [1:0][2:0]     req_rm;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [W-1:0]        rsp_res;
    logic [4:0]          rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_rm, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_rm, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_flags
    );
endinterface

// File: rtl/mul_pipe_arb.sv
// Round-robin arbiter and stage valid/owner tracker for a shared LAT-stage FP multiplier.
// Optional synchronous flush port enabled by defining MUL_PIPE_ARB_FLUSH_EN.
module mul_pipe_arb #(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int LAT    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef MUL_PIPE_ARB_FLUSH_EN
    input  logic                          i_flush,
`endif
    mul_pipe_arb_if.slave                 bus,
    output logic                          o_pipe_en,
    output logic                          o_pipe_in_vld,
    output logic [EXPO_W+MANT_W:0]        o_pipe_a,
    output logic [EXPO_W+MANT_W:0]        o_pipe_b,
    output logic [2:0]                    o_pipe_rm,
    input  logic [EXPO_W+MANT_W:0]        i_pipe_res,
    input  logic [4:0]                    i_pipe_flags,
    output logic [$clog2(LAT+1)-1:0]      o_inflight
);
    localparam int CW = $clog2(LAT + 1);

    logic [LAT-1:0] r_vld;
    logic [LAT-1:0] r_own;
    logic           r_rr_ptr;

    logic [LAT-1:0] w_vld_next;
    logic [LAT-1:0] w_own_next;
    logic           w_flush;
    logic           w_stall;
    logic           w_gnt;
    logic           w_gnt_id;
    logic           w_sel;
    logic           w_issue;
    logic [1:0]     w_ready;
    logic [CW-1:0]  w_inflight;

`ifdef MUL_PIPE_ARB_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // Only an occupied last stage whose owner refuses the result can freeze the pipe.
    assign w_stall = r_vld[LAT-1] & ~bus.rsp_ready[r_own[LAT-1]];

    always_comb begin
        w_gnt_id = 1'b0;
        case (bus.req_valid)
            2'b11:   w_gnt_id = r_rr_ptr;
            2'b10:   w_gnt_id = 1'b1;
            default: w_gnt_id = 1'b0;
        endcase
    end

    assign w_gnt         = (|bus.req_valid) & ~w_stall & ~w_flush & ~rst;
    assign w_ready       = w_gnt ? (2'b01 << w_gnt_id) : 2'b00;
    assign bus.req_ready = w_ready;
    assign w_issue       = |(bus.req_valid & w_ready);
    assign o_pipe_in_vld = w_issue;
    assign o_pipe_en     = ~w_stall;

    // Idle cycles steer requester 0 onto the operand bus.
    assign w_sel     = w_gnt & w_gnt_id;
    assign o_pipe_a  = bus.req_a[w_sel];
    assign o_pipe_b  = bus.req_b[w_sel];
    assign o_pipe_rm = bus.req_rm[w_sel];

    assign bus.rsp_valid = (r_vld[LAT-1] & ~w_flush) ? (2'b01 << r_own[LAT-1]) : 2'b00;
    assign bus.rsp_res   = i_pipe_res;
    assign bus.rsp_flags = i_pipe_flags;

    assign w_vld_next[0] = w_issue;
    assign w_own_next[0] = w_gnt_id;
    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_stage
            assign w_vld_next[gi] = r_vld[gi-1];
            assign w_own_next[gi] = r_own[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= '0;
            r_own    <= '0;
            r_rr_ptr <= 1'b0;
        end else if (w_flush) begin
            r_vld <= '0;
        end else if (o_pipe_en) begin
            r_vld <= w_vld_next;
            r_own <= w_own_next;
            if (w_issue) begin
                r_rr_ptr <= ~w_gnt_id;
            end
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + CW'(r_vld[i]);
        end
    end
    assign o_inflight = w_inflight;
endmodule
